// File: rtl/load_store_unit.sv
// RV32I load/store sequencer: checks alignment and funct3, drives a simple memory port,
// and returns sign/zero-extended load data with a one-cycle completion pulse.
module load_store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] data,
   output logic        done,
   output logic        busy,
   output logic        fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} state_t;

   state_t      state;
   logic [1:0]  wait_cnt;
   logic        req_we;
   logic [2:0]  req_f3;
   logic [1:0]  req_lane;
   logic        req_illegal;
   logic [31:0] st_wdata;
   logic [3:0]  st_wmask;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Legality is judged on the live inputs because it decides the very first transition.
   always_comb begin
      req_illegal = 1'b0;
      if (we)
         req_illegal = (funct3 > 3'b010);
      else
         req_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      if (funct3[1:0] == 2'b01 && addr[0])
         req_illegal = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
         req_illegal = 1'b1;
   end

   always_comb begin
      st_wdata = wdata;
      st_wmask = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{wdata[7:0]}};
            st_wmask = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{wdata[15:0]}};
            st_wmask = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = wdata;
            st_wmask = 4'b1111;
         end
      endcase
   end

   // Lane selection uses only the latched request so late input changes cannot disturb it.
   always_comb begin
      ld_byte = mem_rdata[{req_lane, 3'b000} +: 8];
      ld_half = req_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_f3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 2'd0;
         req_we    <= 1'b0;
         req_f3    <= 3'b000;
         req_lane  <= 2'b00;
         data      <= 32'h0;
         done      <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wmask <= 4'b0000;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  req_we   <= we;
                  req_f3   <= funct3;
                  req_lane <= addr[1:0];
                  busy     <= 1'b1;
                  if (req_illegal) begin
                     state <= ERR;
                     done  <= 1'b1;
                     fault <= 1'b1;
                  end else begin
                     state    <= ACCESS;
                     mem_addr <= {addr[31:2], 2'b00};
                     mem_re   <= ~we;
                     mem_we   <= we;
                     if (we) begin
                        mem_wdata <= st_wdata;
                        mem_wmask <= st_wmask;
                     end
                  end
               end
            end
            ACCESS: begin
               mem_re    <= 1'b0;
               mem_we    <= 1'b0;
               mem_wmask <= 4'b0000;
               if (req_we) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= 2'(READ_LATENCY - 1);
               end
            end
            WAIT: begin
               if (wait_cnt == 2'd0) begin
                  data  <= ld_ext;
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            DONE, ERR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, cycles from mem_re to valid mem_rdata; legal range 1-4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  RV32I width/sign code.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  store data (rs2).
REQ-009 SHALL have port data  output  32  extended load data, feeds result mux data input.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high whenever not IDLE.
REQ-012 SHALL have port fault  output  1  qualifies done; misaligned or illegal funct3.
REQ-013 SHALL have port mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-014 SHALL have ports mem_wdata  output  32, mem_wmask  output  4, mem_we  output  1, mem_re  output  1  memory request signals.
REQ-015 SHALL have port mem_rdata  input  32  read word, valid READ_LATENCY cycles after mem_re.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE, ERR.
REQ-017 IDLE with start=1 at cycle N SHALL latch we, funct3, addr, wdata; go to ERR if request is illegal, else ACCESS in N+1.
REQ-018 Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-019 ACCESS SHALL last exactly one cycle, asserting mem_re (load) or mem_we (store), never both.
REQ-020 Store: ACCESS -> DONE; done pulses in cycle N+2; data unchanged.
REQ-021 Load: ACCESS -> WAIT; a down-counter SHALL hold WAIT until mem_rdata sampled at cycle N+1+READ_LATENCY edge; DONE in N+2+READ_LATENCY.
REQ-022 DONE and ERR SHALL last one cycle, assert done, return to IDLE; fault=1 only in ERR.
REQ-023 ERR SHALL occur in cycle N+1 with no mem_re/mem_we and data unchanged.
REQ-024 SB SHALL drive mem_wdata = wdata[7:0] replicated x4, mem_wmask = 4'b0001 << addr[1:0].
REQ-025 SH SHALL drive wdata[15:0] replicated x2, mask 0011 (addr[1]=0) or 1100; SW: wdata, mask 1111.
REQ-026 mem_wmask SHALL be 0000 whenever mem_we=0.
REQ-027 LB/LBU SHALL select byte lane addr[1:0], sign-/zero-extend; LH/LHU select halfword addr[1]; LW passes word.
REQ-028 data SHALL update in the cycle done rises for a successful load and hold until the next successful load.
REQ-029 start outside IDLE (including DONE/ERR cycle) SHALL be ignored; no queuing.
REQ-030 Request fields SHALL be taken only from the latched copy; input changes after acceptance have no effect.

Reset
REQ-031 rst=1 SHALL force IDLE, clear counter, and zero data, done, busy, fault, mem_re, mem_we, mem_wmask, mem_addr, mem_wdata next edge.
REQ-032 rst mid-operation SHALL abort; any later mem_rdata SHALL be discarded and no done produced.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification
REQ-034 LB, addr=0x103, mem_rdata=0x80FF_1234, READ_LATENCY=1 -> mem_re cycle N+1, mem_addr=0x100, done at N+3, data=0xFFFF_FF80.
REQ-035 LHU, addr=0x202, mem_rdata=0xBEEF_0000 -> data=0x0000_BEEF; LH same -> data=0xFFFF_BEEF.
REQ-036 SB, addr=0x7, wdata=0x1234_56AB -> mem_we one cycle, mem_wdata=0xABAB_ABAB, mem_wmask=1000, done at N+2, data unchanged.
REQ-037 SW, addr=0x6 -> done+fault at N+1, no mem_we/mem_re, busy one cycle.
REQ-038 READ_LATENCY=3, LW with start held high continuously -> done at N+5, data=mem_rdata, second request accepted only in IDLE cycle after done.
REQ-039 rst asserted during WAIT -> IDLE next cycle, all outputs zero, no done pulse.
